// File: rtl/char_pkg.sv
// Shared definitions for the character-map writer.
// Holds character codes, text-grid geometry and the {row, col} layout of the
// 7-bit character-map write address.
// Ports: none (package).
package char_pkg;

    typedef logic [3:0] chr_code_t;

    localparam chr_code_t CHR_BLANK = 4'hF;
    localparam chr_code_t CHR_K     = 4'hC;
    localparam chr_code_t CHR_DOT   = 4'hE;

    localparam int TEXT_ROWS = 12;
    localparam int TEXT_COLS = 8;
    localparam int ROW_W     = 4;
    localparam int COL_W     = $clog2(TEXT_COLS);
    localparam int ADDR_W    = ROW_W + COL_W;

    localparam logic [13:0] VALUE_MAX = 14'd9999;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } char_addr_t;

    function automatic logic [ADDR_W-1:0] char_addr(input logic [ROW_W-1:0] row,
                                                    input logic [COL_W-1:0] col);
        char_addr_t a;
        a.row = row;
        a.col = col;
        return a;
    endfunction

endpackage

// File: rtl/char_map_writer_bin2bcd.sv
// bin2bcd_seq: 14-bit sequential double-dabble converter.
// A start pulse loads din; the following 14 cycles each perform one
// add-3/shift iteration. done is high in the cycle of the final iteration and
// bcd then presents the finished result (the value about to be registered), so
// the consumer can act on it at the same edge the conversion completes.
// Ports:
//   clk_sys  clock
//   rst      asynchronous active-high reset
//   start    load din and begin a conversion
//   din      binary input, expected <= 9999
//   busy     conversion in progress
//   done     final iteration this cycle, bcd valid
//   bcd      four BCD digits, digit 3 in bcd[15:12]
module bin2bcd_seq (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] din,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd
);

    logic [13:0] bin_r;
    logic [15:0] bcd_r;
    logic [3:0]  cnt_r;
    logic [15:0] bcd_adj;
    logic [15:0] bcd_nx;
    logic [13:0] bin_nx;

    always_comb begin
        bcd_adj = bcd_r;
        for (int n = 0; n < 4; n++) begin
            if (bcd_r[4*n +: 4] >= 4'd5)
                bcd_adj[4*n +: 4] = bcd_r[4*n +: 4] + 4'd3;
        end
        {bcd_nx, bin_nx} = {bcd_adj, bin_r} << 1;
    end

    assign done = busy && (cnt_r == 4'd13);
    assign bcd  = bcd_nx;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            bin_r <= '0;
            bcd_r <= '0;
            cnt_r <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            bin_r <= din;
            bcd_r <= '0;
            cnt_r <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            bin_r <= bin_nx;
            bcd_r <= bcd_nx;
            if (cnt_r == 4'd13)
                busy <= 1'b0;
            else
                cnt_r <= cnt_r + 4'd1;
        end
    end

endmodule

// File: rtl/char_map_writer.sv
// char_map_writer: converts a value to four decimal digits and writes their
// character codes into one row of the text-overlay character map.
// Optional feature macro CHAR_LZ_BLANK_EN: when defined, leading zeros in the
// three upper digits are written as blanks; the units digit is always shown.
// Ports:
//   CK, RST                 clock, asynchronous active-high reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_row, req_value      target text row, unsigned value (saturated to 9999)
//   wr_en, wr_addr, wr_data character-map write port, addr = {row, col}
//   done, err, ovf          completion pulse with row-error and saturation flags
module char_map_writer
    import char_pkg::*;
#(
    parameter int ROWS     = TEXT_ROWS,
    parameter int COL_BASE = 0
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_row,
    input  logic [13:0]       req_value,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output chr_code_t         wr_data,
    output logic              done,
    output logic              err,
    output logic              ovf
);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_WRITE, S_DONE} state_t;

    localparam logic [COL_W-1:0] COL0 = COL_W'(COL_BASE);

    state_t      state;
    logic [3:0]  row_r;
    logic        ovf_r;
    logic [1:0]  wr_idx;
    logic [15:0] chars_r;

    logic        accept;
    logic        row_ok;
    logic        value_big;
    logic [13:0] value_sat;
    logic        conv_busy;
    logic        conv_done;
    logic [15:0] conv_bcd;
    logic [15:0] chars;

    assign accept    = req_valid && req_ready && (state == S_IDLE);
    assign row_ok    = {28'd0, req_row} < 32'(ROWS);
    assign value_big = req_value > VALUE_MAX;
    assign value_sat = value_big ? VALUE_MAX : req_value;

    bin2bcd_seq u_bin2bcd (
        .clk_sys (CK),
        .rst     (RST),
        .start   (accept && row_ok),
        .din     (value_sat),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd     (conv_bcd)
    );

    always_comb begin
        chars = conv_bcd;
`ifdef CHAR_LZ_BLANK_EN
        if (conv_bcd[15:12] == 4'd0) begin
            chars[15:12] = CHR_BLANK;
            if (conv_bcd[11:8] == 4'd0) begin
                chars[11:8] = CHR_BLANK;
                if (conv_bcd[7:4] == 4'd0)
                    chars[7:4] = CHR_BLANK;
            end
        end
`endif
    end

    // The first digit is registered at the edge the conversion completes, so
    // the four write cycles follow CONV with no gap.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            req_ready <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            row_r     <= '0;
            ovf_r     <= 1'b0;
            wr_idx    <= '0;
            chars_r   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        row_r     <= req_row;
                        ovf_r     <= value_big;
                        if (row_ok) begin
                            state <= S_CONV;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                            ovf   <= value_big;
                        end
                    end
                end
                S_CONV: begin
                    if (conv_done) begin
                        state   <= S_WRITE;
                        wr_en   <= 1'b1;
                        wr_addr <= char_addr(row_r, COL0);
                        wr_data <= chars[15:12];
                        chars_r <= chars << 4;
                        wr_idx  <= 2'd1;
                    end else if (!conv_busy) begin
                        state <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    if (wr_idx == 2'd0) begin
                        state   <= S_DONE;
                        wr_en   <= 1'b0;
                        wr_addr <= '0;
                        wr_data <= '0;
                        done    <= 1'b1;
                        ovf     <= ovf_r;
                    end else begin
                        wr_addr <= char_addr(row_r, COL0 + COL_W'(wr_idx));
                        wr_data <= chars_r[15:12];
                        chars_r <= chars_r << 4;
                        wr_idx  <= wr_idx + 2'd1;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    done      <= 1'b0;
                    err       <= 1'b0;
                    ovf       <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_char_map_writer.sv
// Directed bench for char_map_writer. Each request is timed relative to its
// accept edge T; expected codes come from a decimal model of the value.
module tb_char_map_writer;

    logic       CK;
    logic       RST;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_row;
    logic [13:0] req_value;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [3:0] wr_data;
    logic       done;
    logic       err;
    logic       ovf;

    int checks = 0;
    int failures = 0;

    int         wr_n;
    int         wr_cyc [8];
    logic [6:0] wr_a [8];
    logic [3:0] wr_d [8];
    int         done_cyc;
    int         ready_cyc;
    logic       err_d;
    logic       ovf_d;

    char_map_writer dut (
        .CK        (CK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_row   (req_row),
        .req_value (req_value),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .done      (done),
        .err       (err),
        .ovf       (ovf)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Code of display digit i (0 = thousands) for value v.
    function automatic logic [3:0] exp_code(input int v, input int i);
        int s;
        int d [4];
        bit lead;
        s = (v > 9999) ? 9999 : v;
        d[0] = s / 1000;
        d[1] = (s / 100) % 10;
        d[2] = (s / 10) % 10;
        d[3] = s % 10;
        lead = 1'b1;
        for (int j = 0; j <= i; j++)
            if (d[j] != 0) lead = 1'b0;
`ifdef CHAR_LZ_BLANK_EN
        if (lead && i < 3) return 4'hF;
`endif
        return 4'(d[i]);
    endfunction

    task automatic do_req(input string tag, input logic [3:0] row, input logic [13:0] val);
        int n;
        @(negedge CK);
        req_row   = row;
        req_value = val;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge CK);
            n++;
        end
        chk({tag, " accept_ready"}, 32'(req_ready), 32'd1);
        @(posedge CK);
        @(negedge CK);
        req_valid = 1'b0;
        req_value = 14'h3FFF;
        req_row   = 4'hF;
        wr_n = 0;
        done_cyc = -1;
        ready_cyc = -1;
        err_d = 1'b0;
        ovf_d = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            if (k > 1) @(negedge CK);
            if (wr_en) begin
                if (wr_n < 8) begin
                    wr_cyc[wr_n] = k;
                    wr_a[wr_n]   = wr_addr;
                    wr_d[wr_n]   = wr_data;
                end
                wr_n++;
            end
            if (done && done_cyc < 0) begin
                done_cyc = k;
                err_d = err;
                ovf_d = ovf;
            end
            if (req_ready && ready_cyc < 0) ready_cyc = k;
        end
    endtask

    task automatic check_req(input string tag, input int row, input int val);
        if (row >= 12) begin
            chk({tag, " wr_count"}, 32'(wr_n), 32'd0);
            chk({tag, " done_cycle"}, 32'(done_cyc), 32'd1);
            chk({tag, " err"}, 32'(err_d), 32'd1);
            chk({tag, " ovf"}, 32'(ovf_d), 32'(val > 9999));
            chk({tag, " ready_cycle"}, 32'(ready_cyc), 32'd2);
        end else begin
            chk({tag, " wr_count"}, 32'(wr_n), 32'd4);
            for (int i = 0; i < 4; i++) begin
                chk({tag, $sformatf(" wr%0d_cycle", i)}, 32'(wr_cyc[i]), 32'(15 + i));
                chk({tag, $sformatf(" wr%0d_addr", i)}, 32'(wr_a[i]), 32'(row * 8 + i));
                chk({tag, $sformatf(" wr%0d_data", i)}, 32'(wr_d[i]), 32'(exp_code(val, i)));
            end
            chk({tag, " done_cycle"}, 32'(done_cyc), 32'd19);
            chk({tag, " err"}, 32'(err_d), 32'd0);
            chk({tag, " ovf"}, 32'(ovf_d), 32'(val > 9999));
            chk({tag, " ready_cycle"}, 32'(ready_cyc), 32'd20);
        end
    endtask

    initial begin
        int n;
        RST       = 1'b1;
        req_valid = 1'b0;
        req_row   = 4'd0;
        req_value = 14'd0;
        repeat (3) @(negedge CK);
        chk("rst req_ready", 32'(req_ready), 32'd0);
        chk("rst wr_en", 32'(wr_en), 32'd0);
        chk("rst wr_addr", 32'(wr_addr), 32'd0);
        chk("rst wr_data", 32'(wr_data), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst ovf", 32'(ovf), 32'd0);
        RST = 1'b0;
        @(negedge CK);
        chk("rst release req_ready", 32'(req_ready), 32'd1);

        do_req("v2200_r0", 4'd0, 14'd2200);
        check_req("v2200_r0", 0, 2200);
        do_req("v800_r7", 4'd7, 14'd800);
        check_req("v800_r7", 7, 800);
        do_req("v0_r11", 4'd11, 14'd0);
        check_req("v0_r11", 11, 0);
        do_req("v12000_r3", 4'd3, 14'd12000);
        check_req("v12000_r3", 3, 12000);
        do_req("v500_r12", 4'd12, 14'd500);
        check_req("v500_r12", 12, 500);
        do_req("v16383_r13", 4'd13, 14'd16383);
        check_req("v16383_r13", 13, 16383);

        // Reset pulse in the middle of WRITE (cycle T+16, second digit).
        @(negedge CK);
        req_row   = 4'd5;
        req_value = 14'd5678;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge CK);
            n++;
        end
        chk("midrst accept_ready", 32'(req_ready), 32'd1);
        @(posedge CK);
        @(negedge CK);
        req_valid = 1'b0;
        repeat (15) @(negedge CK);
        chk("midrst pre wr_en", 32'(wr_en), 32'd1);
        chk("midrst pre wr_addr", 32'(wr_addr), 32'd41);
        chk("midrst pre wr_data", 32'(wr_data), 32'd6);
        RST = 1'b1;
        #1;
        chk("midrst wr_en", 32'(wr_en), 32'd0);
        chk("midrst wr_addr", 32'(wr_addr), 32'd0);
        chk("midrst wr_data", 32'(wr_data), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst req_ready", 32'(req_ready), 32'd0);
        @(negedge CK);
        RST = 1'b0;
        n = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge CK);
            if (wr_en || done) n++;
        end
        chk("midrst no_activity", 32'(n), 32'd0);
        chk("midrst ready_after", 32'(req_ready), 32'd1);

        do_req("v1234_r2", 4'd2, 14'd1234);
        check_req("v1234_r2", 2, 1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
